// File: rtl/clk_div_multi.sv
// Purpose : multi-channel programmable clock divider; each channel makes a 50% square wave of period 2*D CLK cycles.
// Latency : clk_out/tick change on the edge where the counter wraps; load_ack follows an accepted load by one cycle.
// Backpressure: none; a load is always accepted (or dropped if ch_sel is out of range), with no stall.
//
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   en[CHANNELS]    per-channel run enable
//   sync            restart every channel in phase, applying pending divisors
//   load/ch_sel/div_val  one-cycle shadow divisor write to one channel
//   clk_out, tick   per-channel divided clock and toggle pulse (registered)
//   load_ack        one-cycle pulse after an accepted load (registered)
module clk_div_multi #(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   input  logic                load,
   input  logic [3:0]          ch_sel,
   input  logic [CNT_W-1:0]    div_val,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic                load_ack
);

   localparam logic [CNT_W-1:0] DEF_D  = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [4:0]       CH_LIM = 5'(CHANNELS);

   logic ack_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ack_q <= 1'b0;
      end else begin
         // Widen ch_sel so CHANNELS=16 compares correctly.
         ack_q <= load && ({1'b0, ch_sel} < CH_LIM);
      end
   end

   assign load_ack = ack_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_W-1:0] d_q, d_n;   // active divisor
      logic [CNT_W-1:0] s_q, s_n;   // shadow divisor
      logic [CNT_W-1:0] c_q, c_n;   // half-period counter
      logic             p_q, p_n;   // shadow pending
      logic             o_q, o_n;   // divided clock
      logic             t_q, t_n;   // toggle pulse
      logic             hit;
      logic             run;
      logic             wrap;

      // Only channels that exist can match, so out-of-range ch_sel hits nothing.
      assign hit  = load && (ch_sel == 4'(i));
      assign run  = en[i] && (d_q != '0);
      // Full-width compare; d_q is nonzero whenever run is set, so no underflow matters.
      assign wrap = (c_q == (d_q - ONE));

      always_comb begin
         d_n = d_q;
         s_n = s_q;
         p_n = p_q;
         c_n = c_q;
         o_n = o_q;
         t_n = 1'b0;
         if (sync || !run) begin
            // Idle, parked or resynchronised: hold phase at zero and adopt
            // any pending divisor immediately.
            c_n = '0;
            o_n = 1'b0;
            if (p_q) begin
               d_n = s_q;
               p_n = 1'b0;
            end
         end else if (wrap) begin
            // Divisor changes only at a half-period boundary, so a period
            // in flight is never cut short or stretched.
            c_n = '0;
            o_n = ~o_q;
            t_n = 1'b1;
            if (p_q) begin
               d_n = s_q;
               p_n = 1'b0;
            end
         end else begin
            c_n = c_q + ONE;
         end
         // A load lands after any transfer above, so it stays pending.
         if (hit) begin
            s_n = div_val;
            p_n = 1'b1;
         end
      end

      always_ff @(posedge CLK) begin
         if (!RST_N) begin
            d_q <= DEF_D;
            s_q <= DEF_D;
            p_q <= 1'b0;
            c_q <= '0;
            o_q <= 1'b0;
            t_q <= 1'b0;
         end else begin
            d_q <= d_n;
            s_q <= s_n;
            p_q <= p_n;
            c_q <= c_n;
            o_q <= o_n;
            t_q <= t_n;
         end
      end

      assign clk_out[i] = o_q;
      assign tick[i]    = t_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

   localparam int CH  = 4;
   localparam int W   = 8;
   localparam int DEF = 1;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [CH-1:0] en;
   logic          sync;
   logic          load;
   logic [3:0]    ch_sel;
   logic [W-1:0]  div_val;
   logic [CH-1:0] clk_out;
   logic [CH-1:0] tick;
   logic          load_ack;

   always #5 CLK = ~CLK;

   clk_div_multi #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_DIV(DEF)) dut (
      .CLK(CLK), .RST_N(RST_N), .en(en), .sync(sync), .load(load),
      .ch_sel(ch_sel), .div_val(div_val), .clk_out(clk_out), .tick(tick),
      .load_ack(load_ack)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: each channel tracks n = edges elapsed under the current
   // divisor since its last rebase; output = base ^ floor(n/D) parity, tick when
   // n is a multiple of D. A pending divisor rebases the channel at a tick.
   int unsigned md[CH];
   int unsigned ms[CH];
   bit          mp[CH];
   int unsigned mn[CH];
   bit          mbase[CH];
   bit          mout[CH];
   bit          mtick[CH];
   bit          mack;

   function automatic void model_step();
      if (!RST_N) begin
         for (int i = 0; i < CH; i++) begin
            md[i] = DEF; ms[i] = DEF; mp[i] = 0; mn[i] = 0;
            mbase[i] = 0; mout[i] = 0; mtick[i] = 0;
         end
         mack = 0;
         return;
      end
      mack = load && (int'(ch_sel) < CH);
      for (int i = 0; i < CH; i++) begin
         if (sync || !en[i] || md[i] == 0) begin
            mn[i] = 0; mbase[i] = 0; mout[i] = 0; mtick[i] = 0;
            if (mp[i]) begin md[i] = ms[i]; mp[i] = 0; end
         end else begin
            mn[i]++;
            mtick[i] = (mn[i] % md[i]) == 0;
            mout[i]  = mbase[i] ^ bit'((mn[i] / md[i]) % 2);
            if (mtick[i] && mp[i]) begin
               md[i] = ms[i]; mp[i] = 0; mbase[i] = mout[i]; mn[i] = 0;
            end
         end
         if (load && int'(ch_sel) == i) begin
            ms[i] = int'(div_val); mp[i] = 1;
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      logic [CH-1:0] ec, et;
      @(posedge CLK);
      model_step();
      #1;
      for (int i = 0; i < CH; i++) begin ec[i] = mout[i]; et[i] = mtick[i]; end
      check("clk_out", 32'(clk_out), 32'(ec));
      check("tick", 32'(tick), 32'(et));
      check("load_ack", 32'(load_ack), 32'(mack));
   endtask

   task automatic do_load(input int ch, input int v);
      ch_sel = 4'(ch); div_val = W'(v); load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   typedef struct {
      logic          rst_n;
      logic [CH-1:0] en;
      logic          load;
      logic [3:0]    ch_sel;
      logic [W-1:0]  div_val;
      logic [CH-1:0] exp_clk;
      logic [CH-1:0] exp_tick;
      logic          exp_ack;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic prev;
      int   first;
      logic [CH-1:0] ec, et;

      // Reset, CLK/2 defaults, load ch0=3, disable ch3, out-of-range load.
      tbl[0]  = '{1'b0, 4'hF, 1'b0, 4'd0, 8'd0, 4'h0, 4'h0, 1'b0};
      tbl[1]  = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'hF, 4'hF, 1'b0};
      tbl[2]  = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'h0, 4'hF, 1'b0};
      tbl[3]  = '{1'b1, 4'hF, 1'b1, 4'd0, 8'd3, 4'hF, 4'hF, 1'b1};
      tbl[4]  = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'h0, 4'hF, 1'b0};
      tbl[5]  = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'hE, 4'hE, 1'b0};
      tbl[6]  = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'h0, 4'hE, 1'b0};
      tbl[7]  = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'hF, 4'hF, 1'b0};
      tbl[8]  = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'h1, 4'hE, 1'b0};
      tbl[9]  = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'hF, 4'hE, 1'b0};
      tbl[10] = '{1'b1, 4'hF, 1'b0, 4'd0, 8'd0, 4'h0, 4'hF, 1'b0};
      tbl[11] = '{1'b1, 4'h7, 1'b0, 4'd0, 8'd0, 4'h6, 4'h6, 1'b0};
      tbl[12] = '{1'b1, 4'h7, 1'b1, 4'd7, 8'd9, 4'h0, 4'h6, 1'b0};
      tbl[13] = '{1'b1, 4'h7, 1'b0, 4'd0, 8'd0, 4'h7, 4'h7, 1'b0};

      RST_N = 1'b0; en = '1; sync = 1'b0; load = 1'b0; ch_sel = '0; div_val = '0;

      for (int v = 0; v < 14; v++) begin
         RST_N = tbl[v].rst_n; en = tbl[v].en; load = tbl[v].load;
         ch_sel = tbl[v].ch_sel; div_val = tbl[v].div_val; sync = 1'b0;
         @(posedge CLK);
         model_step();
         #1;
         check($sformatf("vec%0d_clk", v), 32'(clk_out), 32'(tbl[v].exp_clk));
         check($sformatf("vec%0d_tick", v), 32'(tick), 32'(tbl[v].exp_tick));
         check($sformatf("vec%0d_ack", v), 32'(load_ack), 32'(tbl[v].exp_ack));
      end
      load = 1'b0;

      // Divisor change mid half-period: 5-cycle half completes, then 2-cycle halves.
      RST_N = 1'b0; en = '1; step(); RST_N = 1'b1;
      do_load(1, 5);
      run(1);
      run(2);
      do_load(1, 2);
      for (int k = 0; k < 6; k++) begin
         prev = clk_out[1];
         step();
         check($sformatf("ch1_toggle_e%0d", k + 4), 32'(clk_out[1] ^ prev), 32'(k % 2));
      end

      // Sync with D=2,3,4: all restart low, realign after 24 cycles.
      do_load(0, 2); do_load(1, 3); do_load(2, 4);
      run(8);
      sync = 1'b1; step(); sync = 1'b0;
      check("sync_clk", 32'(clk_out), 32'h0);
      check("sync_tick", 32'(tick), 32'h0);
      run(23);
      step();
      check("lcm_clk", 32'(clk_out[2:0]), 32'h0);
      check("lcm_tick", 32'(tick[2:0]), 32'h7);

      // Sync and load in the same cycle: load stays pending.
      sync = 1'b1; do_load(0, 3); sync = 1'b0;
      run(6);

      // Divisor 0 parks ch2.
      do_load(2, 0);
      run(6);
      for (int k = 0; k < 8; k++) begin
         step();
         check("park_clk2", 32'(clk_out[2]), 32'h0);
         check("park_tick2", 32'(tick[2]), 32'h0);
      end

      // Largest divisor on ch3: first toggle exactly 255 edges after transfer.
      do_load(3, 255);
      step();
      prev = clk_out[3];
      first = 0;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (first == 0 && clk_out[3] !== prev) first = k;
      end
      check("maxdiv_half", 32'(first), 32'd255);

      // Reset mid-period with a pending load.
      do_load(0, 5);
      run(1);
      RST_N = 1'b0; step(); RST_N = 1'b1;
      check("rst_clk", 32'(clk_out), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      run(4);
      check("rst_def_tick", 32'(tick), 32'hF);

      // Randomised traffic against the model.
      en = '1;
      for (int k = 0; k < 3000; k++) begin
         RST_N = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 49) == 0) en = CH'($urandom);
         if ($urandom_range(0, 29) == 0) en = '1;
         sync    = ($urandom_range(0, 39) == 0);
         load    = ($urandom_range(0, 5) == 0);
         ch_sel  = 4'($urandom_range(0, 7));
         div_val = W'($urandom_range(0, 6));
         step();
      end
      sync = 1'b0; load = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
